// File: rtl/stpw_ctrl_unit.sv
// Stopwatch control unit: merges button pulses and UART commands into one
// event per cycle, runs the STOP/RUN/CLEAR FSM and holds the lap freeze-frame.
module stpw_ctrl_unit #(
  parameter logic [7:0] CMD_RUN = 8'h52,
  parameter logic [7:0] CMD_CLR = 8'h43,
  parameter logic [7:0] CMD_LAP = 8'h4C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_run,
  input  logic       i_btn_clr,
  input  logic       i_btn_lap,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  output logic       o_run,
  output logic       o_clr,
  output logic [1:0] o_state,
  output logic       o_lap_hold,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_cmd_drop
);

  typedef enum logic [1:0] {
    ST_STOP    = 2'b00,
    ST_RUN     = 2'b01,
    ST_CLEAR   = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  // EV_NONE doubles as the "pending register empty" marker.
  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_RUN  = 2'b01,
    EV_CLR  = 2'b10,
    EV_LAP  = 2'b11
  } event_t;

  state_t     state, state_nx;
  event_t     rx_cmd, pend_cmd, ev;
  logic       btn_any, pend_take;
  logic       lap_hold, hold_nx, capture;
  logic [6:0] lap_msec;
  logic [5:0] lap_sec, lap_min;
  logic [4:0] lap_hour;

  // Case-insensitive decode: OR-ing 8'h20 maps an uppercase letter to lowercase.
  always_comb begin
    rx_cmd = EV_NONE;
    if (i_rx_valid) begin
      if ((i_rx_data == CMD_RUN) || (i_rx_data == (CMD_RUN | 8'h20)))      rx_cmd = EV_RUN;
      else if ((i_rx_data == CMD_CLR) || (i_rx_data == (CMD_CLR | 8'h20))) rx_cmd = EV_CLR;
      else if ((i_rx_data == CMD_LAP) || (i_rx_data == (CMD_LAP | 8'h20))) rx_cmd = EV_LAP;
    end
  end

  assign btn_any   = i_btn_run | i_btn_clr | i_btn_lap;
  assign pend_take = (pend_cmd != EV_NONE) && !btn_any;

  always_comb begin
    if (i_btn_run)      ev = EV_RUN;
    else if (i_btn_clr) ev = EV_CLR;
    else if (i_btn_lap) ev = EV_LAP;
    else if (pend_take) ev = pend_cmd;
    else                ev = EV_NONE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_cmd   <= EV_NONE;
      o_cmd_drop <= 1'b0;
    end else begin
      o_cmd_drop <= (rx_cmd != EV_NONE) && (pend_cmd != EV_NONE) && !pend_take;
      if (rx_cmd != EV_NONE) pend_cmd <= rx_cmd;
      else if (pend_take)    pend_cmd <= EV_NONE;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    hold_nx  = lap_hold;
    capture  = 1'b0;
    case (state)
      ST_STOP: begin
        case (ev)
          EV_RUN:  state_nx = ST_RUN;
          EV_CLR: begin
            state_nx = ST_CLEAR;
            hold_nx  = 1'b0;
          end
          EV_LAP:  hold_nx = 1'b0;
          default: ;
        endcase
      end
      ST_RUN: begin
        case (ev)
          EV_RUN: state_nx = ST_STOP;
          EV_LAP: begin
            hold_nx = !lap_hold;
            capture = !lap_hold;
          end
          default: ;
        endcase
      end
      ST_CLEAR: state_nx = ST_STOP;
      default:  state_nx = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_STOP;
      lap_hold <= 1'b0;
    end else begin
      state    <= state_nx;
      lap_hold <= hold_nx;
    end
  end

  // Lap registers survive CLEAR; only reset wipes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_msec <= '0;
      lap_sec  <= '0;
      lap_min  <= '0;
      lap_hour <= '0;
    end else if (capture) begin
      lap_msec <= i_msec;
      lap_sec  <= i_sec;
      lap_min  <= i_min;
      lap_hour <= i_hour;
    end
  end

  assign o_state    = state;
  assign o_run      = (state == ST_RUN);
  assign o_clr      = (state == ST_CLEAR);
  assign o_lap_hold = lap_hold;
  assign o_msec     = lap_hold ? lap_msec : i_msec;
  assign o_sec      = lap_hold ? lap_sec  : i_sec;
  assign o_min      = lap_hold ? lap_min  : i_min;
  assign o_hour     = lap_hold ? lap_hour : i_hour;

endmodule
